// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: FSM states, gain, pi, and the Q2.30 arctangent table.
package cordic_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned INT_W  = 34;
   localparam int unsigned IDX_W  = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [31:0] K_GAIN  = 32'h26DD3B6A;
   localparam logic [31:0] PI_HALF = 32'h6487ED51;
   localparam logic [33:0] PI_Q    = 34'h0C90FDAA2;

   // atan(2^-i) in Q2.30, rounded to nearest
   localparam logic [31:0] ATAN_TAB [32] = '{
      32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
      32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
      32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
      32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
      32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
      32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080,
      32'h00000040, 32'h00000020, 32'h00000010, 32'h00000008,
      32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
   };

   // clamp a 34-bit internal value into the signed 32-bit output range
   function automatic logic [31:0] sat32(input logic signed [33:0] v);
      if (v[33:31] != {3{v[31]}})
         return v[33] ? 32'h80000000 : 32'h7FFFFFFF;
      return v[31:0];
   endfunction

endpackage

// File: rtl/cordic_sincos_stage.sv
// One combinational rotation-mode CORDIC micro-rotation at step i.
module cordic_sincos_stage
   import cordic_pkg::*;
(
   input  logic signed [33:0] x,
   input  logic signed [33:0] y,
   input  logic signed [33:0] z,
   input  logic [4:0]         i,
   output logic signed [33:0] x_next,
   output logic signed [33:0] y_next,
   output logic signed [33:0] z_next
);

   logic signed [33:0] x_sh;
   logic signed [33:0] y_sh;
   logic signed [33:0] atan_i;

   assign x_sh   = x >>> i;
   assign y_sh   = y >>> i;
   assign atan_i = 34'(ATAN_TAB[i]);

   // rotate toward z == 0
   always_comb begin
      x_next = x;
      y_next = y;
      z_next = z;
      if (!z[33]) begin
         x_next = x - y_sh;
         y_next = y + x_sh;
         z_next = z - atan_i;
      end else begin
         x_next = x + y_sh;
         y_next = y - x_sh;
         z_next = z + atan_i;
      end
   end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative CORDIC sin/cos engine, one micro-rotation per clock, valid/ready on both sides.
// Optional quadrant folding for the full [-2,2) input range: CORDIC_SINCOS_QUAD_FOLD_EN.
module cordic_sincos
   import cordic_pkg::*;
#(
   parameter int unsigned ITER = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_angle,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_cos,
   output logic [31:0] out_sin
);

   localparam logic [4:0] LAST_IDX = 5'(ITER - 1);

   state_t             state;
   logic [4:0]         idx;
   logic signed [33:0] x, y, z;
   logic signed [33:0] x_next, y_next, z_next;
   logic signed [33:0] res_x, res_y;
   logic signed [33:0] angle_ext;

   assign angle_ext = {{2{in_angle[31]}}, in_angle};

   cordic_sincos_stage u_stage (
      .x      (x),
      .y      (y),
      .z      (z),
      .i      (idx),
      .x_next (x_next),
      .y_next (y_next),
      .z_next (z_next)
   );

`ifdef CORDIC_SINCOS_QUAD_FOLD_EN
   localparam logic signed [33:0] PI_HALF_EXT = 34'(PI_HALF);
   localparam logic signed [33:0] PI_EXT      = PI_Q;

   logic fold;
   logic signed [33:0] z_load;
   logic               fold_load;

   // map |angle| > pi/2 into range by a half turn; the result sign flips back at DONE
   always_comb begin
      z_load    = angle_ext;
      fold_load = 1'b0;
      if (angle_ext > PI_HALF_EXT) begin
         z_load    = angle_ext - PI_EXT;
         fold_load = 1'b1;
      end else if (angle_ext < -PI_HALF_EXT) begin
         z_load    = angle_ext + PI_EXT;
         fold_load = 1'b1;
      end
   end

   assign res_x = fold ? -x_next : x_next;
   assign res_y = fold ? -y_next : y_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fold <= 1'b0;
      else if (state == IDLE && in_valid)
         fold <= fold_load;
   end
`else
   logic signed [33:0] z_load;

   assign z_load = angle_ext;
   assign res_x  = x_next;
   assign res_y  = y_next;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_cos   <= '0;
         out_sin   <= '0;
         x         <= '0;
         y         <= '0;
         z         <= '0;
         idx       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x        <= 34'(K_GAIN);
                  y        <= '0;
                  z        <= z_load;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= ROTATE;
               end
            end
            ROTATE: begin
               x <= x_next;
               y <= y_next;
               z <= z_next;
               if (idx == LAST_IDX) begin
                  out_cos   <= sat32(res_x);
                  out_sin   <= sat32(res_y);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + 5'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_sincos.sv
// Self-checking bench for cordic_sincos: vector table, random angles vs real-math model,
// backpressure and mid-transaction reset sequences.
module tb_cordic_sincos;

   localparam int unsigned ITER = 24;
   localparam longint      TOL  = 128;
   localparam longint      ONE  = 64'sd1073741824;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_angle;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_cos;
   logic [31:0] out_sin;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cordic_sincos #(.ITER(ITER)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_angle  (in_angle),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cos   (out_cos),
      .out_sin   (out_sin)
   );

   typedef struct {
      logic [31:0] angle;
      longint      cos_e;
      longint      sin_e;
   } vec_t;

   task automatic chk_bit(input string name, input logic got, input logic exp_v);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, got, exp_v);
      end
   endtask

   task automatic chk_int(input string name, input longint got, input longint exp_v);
      checks++;
      if (got != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
      end
   endtask

   task automatic chk_near(input string name, input logic [31:0] got, input longint exp_v);
      longint d;
      checks++;
      d = longint'($signed(got)) - exp_v;
      if (d < 0) d = -d;
      if ($isunknown(got) || d > TOL) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (+/-%0d)", name, $signed(got), exp_v, TOL);
      end
   endtask

   function automatic real to_rad(input logic [31:0] a);
      return real'($signed(a)) / 1073741824.0;
   endfunction

   function automatic longint to_q30(input real r);
      return longint'($rtoi(r * 1073741824.0));
   endfunction

   // present one request, collect the result and the cycles from acceptance to out_valid
   task automatic run_one(input logic [31:0] a, output logic [31:0] c,
                          output logic [31:0] s, output int lat);
      int w;
      @(negedge clk);
      in_angle  = a;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk_bit("accept_ready", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      c = out_cos;
      s = out_sin;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      vec_t        tab[4];
      logic [31:0] c, s, a, hc, hs;
      int          lat, w;
      logic        seen;

      tab[0] = '{32'h00000000, ONE, 0};
      tab[1] = '{32'h3243F6A9, 759250125, 759250125};
      tab[2] = '{32'h6487ED51, 0, ONE};
      tab[3] = '{32'h9B7812AF, 0, -ONE};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_angle  = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk_bit("reset_in_ready", in_ready, 1'b1);
      chk_bit("reset_out_valid", out_valid, 1'b0);
      chk_int("reset_out_cos", longint'(out_cos), 0);
      chk_int("reset_out_sin", longint'(out_sin), 0);
      rst_n = 1'b1;

      for (int k = 0; k < 4; k++) begin
         run_one(tab[k].angle, c, s, lat);
         chk_int($sformatf("vec%0d_latency", k), lat, ITER);
         chk_near($sformatf("vec%0d_cos", k), c, tab[k].cos_e);
         chk_near($sformatf("vec%0d_sin", k), s, tab[k].sin_e);
      end

      for (int k = 0; k < 16; k++) begin
`ifdef CORDIC_SINCOS_QUAD_FOLD_EN
         a = $urandom();
`else
         a = 32'(longint'($urandom_range(32'hC90FDAA2, 0)) - 64'sd1686629713);
`endif
         run_one(a, c, s, lat);
         chk_near($sformatf("rand%0d_cos a=%08h", k, a), c, to_q30($cos(to_rad(a))));
         chk_near($sformatf("rand%0d_sin a=%08h", k, a), s, to_q30($sin(to_rad(a))));
      end

`ifdef CORDIC_SINCOS_QUAD_FOLD_EN
      run_one(32'h73333333, c, s, lat);
      chk_near("fold_1p8_cos", c, -243956387);
      chk_near("fold_1p8_sin", s, 1045660931);
      run_one(32'h80000000, c, s, lat);
      chk_near("fold_m2_cos", c, to_q30($cos(-2.0)));
      chk_near("fold_m2_sin", s, to_q30($sin(-2.0)));
`endif

      // backpressure: result held 10 cycles while a second request waits
      @(negedge clk);
      in_angle = 32'h3243F6A9;
      in_valid = 1'b1;
      @(negedge clk);
      in_angle = 32'h00000000;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk_int("bp_latency", lat, ITER);
      hc = out_cos;
      hs = out_sin;
      chk_near("bp_cos", hc, 759250125);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk_bit("bp_valid_held", out_valid, 1'b1);
         chk_bit("bp_in_ready_low", in_ready, 1'b0);
         chk_int("bp_cos_stable", longint'(out_cos), longint'(hc));
         chk_int("bp_sin_stable", longint'(out_sin), longint'(hs));
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk_bit("bp_idle_valid", out_valid, 1'b0);
      chk_bit("bp_idle_ready", in_ready, 1'b1);
      @(negedge clk);
      chk_bit("bp_second_accepted", in_ready, 1'b0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk_int("bp2_latency", lat, ITER);
      chk_near("bp2_cos", out_cos, ONE);
      chk_near("bp2_sin", out_sin, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // reset at iteration 10: work discarded, no stray result afterwards
      @(negedge clk);
      in_angle = 32'h3243F6A9;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_bit("rst_rot_valid", out_valid, 1'b0);
      chk_bit("rst_rot_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk_bit("rst_no_stray_result", seen, 1'b0);
      run_one(32'h00000000, c, s, lat);
      chk_int("rst_after_latency", lat, ITER);
      chk_near("rst_after_cos", c, ONE);
      chk_near("rst_after_sin", s, 0);

      // reset while a result is waiting in DONE
      @(negedge clk);
      in_angle = 32'h6487ED51;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk_bit("rst_done_reached", out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_bit("rst_done_valid", out_valid, 1'b0);
      chk_bit("rst_done_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cordic_sincos.md
# cordic_sincos

Iterative rotation-mode CORDIC engine that converts a Q2.30 radian angle into cosine and sine, both Q2.30. It is the angle-to-vector counterpart of the arctangent constant table in the FPU's trigonometric datapath. It performs one micro-rotation per clock and sits behind a valid/ready request interface and in front of a valid/ready result interface.

## Interface
- ITER, 24: micro-rotations per request; legal range 1..31.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept a request.
- in_angle  in  32  signed Q2.30 radians, range [-2.0, 2.0).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_cos  out  32  signed Q2.30 cosine.
- out_sin  out  32  signed Q2.30 sine.

## Operation
- FSM has three states: IDLE, ROTATE, DONE. Reset puts it in IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, load x=K=32'h26DD3B6A (gain 0.6072529350), y=0, z=in_angle (internally sign-extended to 34 bits), i=0. Go to ROTATE.
- ROTATE, one micro-rotation per cycle:
  - d = (z>=0) ? +1 : -1.
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan_i.
  - atan_i is the 32-bit Q2.30 constant atan(2^-i); table entries 0..31 start at 32'h3243f6a9, 32'h1dac6705, 32'h0fadbafd.
  - Shifts are arithmetic. x and y are 34-bit internally for guard headroom.
  - When i==ITER-1, go to DONE; otherwise i++.
- DONE:
  - out_valid=1.
  - Outputs are x and y saturated to 32-bit signed.
  - On out_ready, go to IDLE.
- in_ready is 1 only in IDLE. A request presented while busy is held off, not dropped.
- Outputs are stable while out_valid=1 && out_ready=0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_cos=0, out_sin=0; state IDLE, i=0.
- Latency: a request accepted at edge E0 produces out_valid=1 in the cycle after edge E_ITER, i.e. ITER cycles after acceptance.
- Throughput: one result per ITER+2 cycles with out_ready tied high (accept, ITER rotations, DONE handshake cycle).
- In IDLE, in_ready is combinational from state only, with no dependence on in_valid.
- If out_ready=1 in the DONE cycle, the FSM returns to IDLE on the next edge. The next request is accepted no earlier than one cycle later; there is no DONE->ROTATE bypass.
- rst_n asserted mid-ROTATE or mid-DONE:
  - Immediately clears out_valid and returns the FSM to IDLE.
  - The result in progress is discarded; no partial result is ever presented.
- ITER=1 is legal: exactly one rotation, then DONE.
- Accuracy: |error| <= 2^(30-ITER)+4 LSB per output.

## Configuration
- CORDIC_SINCOS_QUAD_FOLD_EN defined:
  - At load, if |in_angle| > pi/2 (32'h6487ED51), z is loaded with in_angle - pi (in_angle > 0) or in_angle + pi (in_angle < 0), using 34-bit pi = 34'h0C90FDAA2.
  - A fold flag is registered. When set, x and y are negated on the transfer into DONE.
  - Full input range [-2.0, 2.0) is valid.
- Not defined:
  - No fold logic and no fold flag.
  - Input is specified over [-pi/2, pi/2] only; results outside that range are unspecified but never X, and the handshake remains correct.

## Structure
- Shared package cordic_pkg holds:
  - the state enum;
  - the gain constant K;
  - the Q2.30 constants for pi and pi/2;
  - the 32-entry arctangent constant array, so both CORDIC directions share one source.
- One sub-module is natural: cordic_sincos_stage, a combinational single micro-rotation (x, y, z, i in; x', y', z' out) instantiated once and reused iteratively.

## Test plan
- Tolerance in all scenarios: ±128 LSB at ITER=24.
- Angle 0 -> cos≈32'h40000000, sin≈0; out_valid exactly 24 cycles after acceptance.
- Angle 32'h3243F6A9 (pi/4) -> cos≈sin≈32'h2D413CCD.
- Angle 32'h6487ED51 (pi/2) -> cos≈0, sin≈32'h40000000. Angle 32'h9B7812AF (-pi/2) -> sin≈32'hC0000000.
- With CORDIC_SINCOS_QUAD_FOLD_EN: angle 32'h73333333 (1.8 rad) -> cos≈-243956387, sin≈1045660931.
- Backpressure: hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0 throughout, second in_valid held. Then out_ready=1 -> handshake, return to IDLE, second request accepted the following cycle.
- Deassert rst_n at iteration 10 -> out_valid=0, in_ready=1 immediately. After release, a new request (angle 0) completes with a correct result 24 cycles later.
